// File: rtl/valu_wb_sched.sv
// valu_wb_sched: writeback-slot scheduler issuing ops to fixed-latency vALU units sharing one writeback port
//   Parameters: REQ_ADDR_WIDTH (dest address width), NUM_UNITS (unit count), LAT_WIDTH (latency field width)
//   Ports: clk; rst (async, active-low); in_valid/in_ready issue handshake with in_unit, in_lat,
//          in_addr, in_w_reg, in_drain; out_issue (one-hot unit strobe), out_addr, out_w_reg;
//          out_wb_expect (writeback due this cycle); out_idle (nothing in flight)
//   Optional: define VALU_WB_SCHED_STATS_EN to add stat_issued / stat_stalled saturating counters
module valu_wb_sched #(
    parameter int REQ_ADDR_WIDTH = 32,
    parameter int NUM_UNITS      = 4,
    parameter int LAT_WIDTH      = 4,
    localparam int UW            = NUM_UNITS > 1 ? $clog2(NUM_UNITS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [UW-1:0]             in_unit,
    input  logic [LAT_WIDTH-1:0]      in_lat,
    input  logic [REQ_ADDR_WIDTH-1:0] in_addr,
    input  logic                      in_w_reg,
    input  logic                      in_drain,
    output logic [NUM_UNITS-1:0]      out_issue,
    output logic [REQ_ADDR_WIDTH-1:0] out_addr,
    output logic                      out_w_reg,
    output logic                      out_wb_expect,
    output logic                      out_idle
`ifdef VALU_WB_SCHED_STATS_EN
    ,
    output logic [15:0]               stat_issued,
    output logic [15:0]               stat_stalled
`endif
);
    localparam int MAX_LAT = 2**LAT_WIDTH - 1;
    localparam int RW      = MAX_LAT + 1;
    localparam int CW      = LAT_WIDTH + 1;
    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;
    state_t                    r_state, w_state_nxt;
    logic [RW-1:0]             r_rsv, w_shift, w_rsv_nxt;
    logic [CW-1:0]             r_cnt;
    logic [NUM_UNITS-1:0]      r_issue;
    logic [REQ_ADDR_WIDTH-1:0] r_addr;
    logic                      r_w_reg;
    logic                      w_accept, w_unit_ok;
    // w_shift is the reservation vector as seen after the next edge; a request with
    // latency L lands L cycles after that edge, so its slot is w_shift[L].
    assign w_shift       = r_rsv >> 1;
    assign w_unit_ok     = int'(in_unit) < NUM_UNITS;
    assign in_ready      = r_state == S_ACTIVE && !in_drain && in_lat != '0 && w_unit_ok && !w_shift[in_lat];
    assign w_accept      = in_valid && in_ready;
    assign w_rsv_nxt     = w_shift | (w_accept ? RW'(1) << in_lat : '0);
    assign out_issue     = r_issue;
    assign out_addr      = r_addr;
    assign out_w_reg     = r_w_reg;
    assign out_wb_expect = r_rsv[0];
    assign out_idle      = r_cnt == '0;
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:   w_state_nxt = S_ACTIVE;
            S_ACTIVE: w_state_nxt = in_drain ? S_DRAIN : S_ACTIVE;
            S_DRAIN:  w_state_nxt = !in_drain && r_cnt == '0 ? S_ACTIVE : S_DRAIN;
            default:  w_state_nxt = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_rsv   <= '0;
            r_cnt   <= '0;
            r_issue <= '0;
            r_addr  <= '0;
            r_w_reg <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rsv   <= w_rsv_nxt;
            r_cnt   <= r_cnt + CW'(w_accept) - CW'(r_rsv[0]);
            r_issue <= w_accept ? NUM_UNITS'(1) << in_unit : '0;
            r_addr  <= w_accept ? in_addr : '0;
            r_w_reg <= w_accept && in_w_reg;
        end
    end
`ifdef VALU_WB_SCHED_STATS_EN
    logic [15:0] r_stat_issued, r_stat_stalled;
    assign stat_issued  = r_stat_issued;
    assign stat_stalled = r_stat_stalled;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat_issued  <= '0;
            r_stat_stalled <= '0;
        end else begin
            r_stat_issued  <= r_stat_issued + 16'(w_accept && r_stat_issued != 16'hFFFF);
            r_stat_stalled <= r_stat_stalled + 16'(in_valid && !in_ready && r_stat_stalled != 16'hFFFF);
        end
    end
`endif
endmodule

// File: doc/valu_wb_sched.md
VALU_WB_SCHED -- requirements
Module: valu_wb_sched

Interface
REQ-001 Parameter REQ_ADDR_WIDTH, default 32, SHALL set the destination address width.
REQ-002 Parameter NUM_UNITS, default 4, SHALL set the number of fixed-latency vALU units sharing one writeback port.
REQ-003 Parameter LAT_WIDTH, default 4, SHALL set the width of the per-request latency field; max latency MAX_LAT = 2^LAT_WIDTH-1.
REQ-004 Port clk, input, 1, SHALL be the single clock; all state on rising edge.
REQ-005 Port rst, input, 1, SHALL be the asynchronous, active-low reset.
REQ-006 Port in_valid, input, 1, SHALL flag a pending issue request.
REQ-007 Port in_ready, output, 1, SHALL indicate the request is accepted this cycle.
REQ-008 Port in_unit, input, clog2(NUM_UNITS), SHALL select the target unit.
REQ-009 Port in_lat, input, LAT_WIDTH, SHALL give the unit latency L in cycles, from unit in_valid to unit out_valid; vMove is 6.
REQ-010 Port in_addr, input, REQ_ADDR_WIDTH, SHALL give the destination address.
REQ-011 Port in_w_reg, input, 1, SHALL give the write-register flag.
REQ-012 Port in_drain, input, 1, SHALL request a stop to new issue until all in-flight ops retire.
REQ-013 Port out_issue, output, NUM_UNITS, SHALL be the one-hot unit in_valid strobe.
REQ-014 Port out_addr, output, REQ_ADDR_WIDTH, and port out_w_reg, output, 1, SHALL carry the issued op's fields to the units.
REQ-015 Port out_wb_expect, output, 1, SHALL pulse in the cycle a unit writeback is due.
REQ-016 Port out_idle, output, 1, SHALL be high when no op is in flight.

Function
REQ-017 A handshake SHALL occur in cycle t when in_valid && in_ready; out_issue[in_unit], out_addr and out_w_reg SHALL be registered and valid in cycle t+1 only.
REQ-018 A reservation vector rsv[MAX_LAT:0] SHALL shift toward bit 0 every cycle; bit k set means a writeback is due k cycles after the current edge.
REQ-019 in_ready SHALL be combinationally low if the slot for cycle t+1+in_lat is already reserved, if state is not ACTIVE, or if in_lat == 0.
REQ-020 An accepted op SHALL reserve slot t+1+L, so out_wb_expect is high exactly in cycle t+1+L.
REQ-021 At most one reservation SHALL exist per cycle; no two accepted ops may share a writeback cycle.
REQ-022 An in-flight counter SHALL increment on accept and decrement on out_wb_expect; simultaneous accept and retire SHALL leave it unchanged; out_idle = (count == 0).
REQ-023 The FSM SHALL have states IDLE, ACTIVE and DRAIN.
REQ-024 IDLE SHALL be the reset state; IDLE SHALL go to ACTIVE in the first cycle after reset deassertion.
REQ-025 ACTIVE SHALL go to DRAIN when in_drain is high, and DRAIN SHALL go to ACTIVE when in_drain is low and the counter is 0.
REQ-026 in_drain high in the same cycle as a valid request SHALL block that request.
REQ-027 Ops already reserved SHALL still retire during DRAIN.
REQ-028 out_issue SHALL be all-zero in any cycle without a prior-cycle accept; out_addr and out_w_reg SHALL be 0 then.
REQ-029 An out-of-range in_unit (>= NUM_UNITS) SHALL not be accepted; in_ready SHALL be low for it.

Reset
REQ-030 On rst low, asynchronously: rsv=0, counter=0, state=IDLE.
REQ-031 On rst low, asynchronously: out_issue=0, out_addr=0, out_w_reg=0, out_wb_expect=0, out_idle=1, in_ready=0.
REQ-032 Reset mid-operation SHALL discard all reservations; units are reset by the same signal.

Configuration
REQ-033 With VALU_WB_SCHED_STATS_EN defined, the block SHALL add outputs stat_issued[15:0] (accepts) and stat_stalled[15:0] (cycles with in_valid && !in_ready), both saturating at 0xFFFF and reset to 0.
REQ-034 Without VALU_WB_SCHED_STATS_EN, those ports and counters SHALL be absent and function SHALL be identical.

Verification
REQ-035 Single op: accept unit 1, L=6, addr 0x40 at cycle 10 -> out_issue=4'b0010, out_addr=0x40 at 11; out_wb_expect at 17 only; out_idle high at 18.
REQ-036 Collision: accept L=6 at cycle 10, request L=5 at 11 -> in_ready low at 11; the same request accepted at 12 -> wb at 17 and 18.
REQ-037 Back-to-back: L=3 ops accepted in cycles 5,6,7 -> out_wb_expect high in 9,10,11; counter peaks at 3.
REQ-038 Drain: in_drain high at 20 with 2 ops in flight -> in_ready low; ACTIVE re-entered only after both wb pulses and in_drain low.
REQ-039 Async reset asserted at cycle 14 with an op due at 17 -> all outputs at reset values immediately; no wb pulse at 17.
REQ-040 STATS_EN build: 3 accepts and 2 stall cycles -> stat_issued=3, stat_stalled=2.
